// File: rtl/rtmc_seq.sv
`default_nettype none
// ============================================================================
// Module   : rtmc_seq
// Brief    : SPI mode-0 programmed pattern sequencer driving CHANNELS outputs
//            from a DEPTH-entry step memory. Option macro: RTMC_SEQ_READBACK_EN
// Revision : 1.0 - initial release
// ============================================================================
module rtmc_seq #(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 16,
    parameter int GPI_W    = 4,
    parameter int TICK_DIV = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sck,
    input  logic                cs_n,
    input  logic                sdi,
    output logic                sdo,
    input  logic [GPI_W-1:0]    gpi,
    output logic [CHANNELS-1:0] mc,
    output logic [CHANNELS-1:0] mc_oe,
    output logic                busy
);

    localparam int                c_addr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                c_tick_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [4:0]        c_depth     = 5'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ---------------- input synchronisers ----------------
    logic [2:0]       r_sck_sync;
    logic [1:0]       r_cs_sync;
    logic [1:0]       r_sdi_sync;
    logic [GPI_W-1:0] r_gpi_s1;
    logic [GPI_W-1:0] r_gpi_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_sync <= 3'b000;
            r_cs_sync  <= 2'b11;
            r_sdi_sync <= 2'b00;
            r_gpi_s1   <= '0;
            r_gpi_s2   <= '0;
        end else begin
            r_sck_sync <= {r_sck_sync[1:0], sck};
            r_cs_sync  <= {r_cs_sync[0], cs_n};
            r_sdi_sync <= {r_sdi_sync[0], sdi};
            r_gpi_s1   <= gpi;
            r_gpi_s2   <= r_gpi_s1;
        end
    end

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_active;
    logic w_sdi;

    assign w_sck_rise  =  r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall  = ~r_sck_sync[1] &  r_sck_sync[2];
    assign w_cs_active = ~r_cs_sync[1];
    assign w_sdi       =  r_sdi_sync[1];

    // ---------------- register file / sequencer state ----------------
    logic                r_ctrl_run;
    logic                r_ctrl_loop;
    logic [c_addr_w-1:0] r_ctrl_last;
    logic                r_ctrl_wr;

    logic [CHANNELS-1:0] r_pat  [DEPTH];
    logic [CHANNELS-1:0] r_oe   [DEPTH];
    logic [7:0]          r_dur  [DEPTH];
    logic [GPI_W-1:0]    r_mask [DEPTH];

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_addr_w-1:0] r_step;
    logic [c_tick_w-1:0] r_tick;
    logic [7:0]          r_dcnt;
    logic [7:0]          r_cur_dur;
    logic [GPI_W-1:0]    r_cur_mask;
    logic [CHANNELS-1:0] r_mc;
    logic [CHANNELS-1:0] r_oe_out;

    // ---------------- SPI slave ----------------
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [7:0] r_byte;
    logic       r_byte_done;
    logic       r_cmd_phase;
    logic       r_wr_mode;
    logic [6:0] r_addr;
    logic [7:0] r_tx;
    logic       r_sdo;
    logic [6:0] w_rd_addr;
    logic [7:0] w_rdata;
    logic       w_we;
    logic [3:0] w_wk;

    // The byte following the command is fetched from the command address,
    // every later one from the address after the one just transferred.
    assign w_rd_addr = r_cmd_phase ? r_byte[6:0] : (r_addr + 7'd1);
    assign w_we      = r_byte_done & ~r_cmd_phase & r_wr_mode;
    assign w_wk      = r_addr[5:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_byte      <= 8'd0;
            r_byte_done <= 1'b0;
            r_cmd_phase <= 1'b1;
            r_wr_mode   <= 1'b0;
            r_addr      <= 7'd0;
            r_tx        <= 8'd0;
            r_sdo       <= 1'b0;
        end else if (!w_cs_active) begin
            r_bit_cnt   <= 3'd0;
            r_byte_done <= 1'b0;
            r_cmd_phase <= 1'b1;
            r_tx        <= 8'd0;
            r_sdo       <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            if (w_sck_rise) begin
                r_shift   <= {r_shift[5:0], w_sdi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte      <= {r_shift, w_sdi};
                    r_byte_done <= 1'b1;
                end
            end
            if (w_sck_fall) begin
                r_sdo <= r_tx[7];
                r_tx  <= {r_tx[6:0], 1'b0};
            end
            if (r_byte_done) begin
                if (r_cmd_phase) begin
                    r_cmd_phase <= 1'b0;
                    r_wr_mode   <= r_byte[7];
                    r_addr      <= r_byte[6:0];
                end else begin
                    r_addr <= r_addr + 7'd1;
                end
                r_tx <= w_rdata;
            end
        end
    end

    assign sdo = r_sdo;

    always_comb begin
        w_rdata = 8'd0;
        if (w_rd_addr == 7'h00) begin
            w_rdata = {4'(r_ctrl_last), 2'b00, r_ctrl_loop, r_ctrl_run};
        end else if (w_rd_addr == 7'h01) begin
            w_rdata = {4'(r_step), 2'b00, r_state};
        end
`ifdef RTMC_SEQ_READBACK_EN
        else if (w_rd_addr[6] && ({1'b0, w_rd_addr[5:2]} < c_depth)) begin
            case (w_rd_addr[1:0])
                2'd0:    w_rdata = 8'(r_pat[w_rd_addr[2 +: c_addr_w]]);
                2'd1:    w_rdata = 8'(r_oe[w_rd_addr[2 +: c_addr_w]]);
                2'd2:    w_rdata = r_dur[w_rd_addr[2 +: c_addr_w]];
                default: w_rdata = 8'(r_mask[w_rd_addr[2 +: c_addr_w]]);
            endcase
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_run  <= 1'b0;
            r_ctrl_loop <= 1'b0;
            r_ctrl_last <= '0;
            r_ctrl_wr   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pat[i]  <= '0;
                r_oe[i]   <= '0;
                r_dur[i]  <= '0;
                r_mask[i] <= '0;
            end
        end else begin
            r_ctrl_wr <= 1'b0;
            if (w_we) begin
                if (r_addr == 7'h00) begin
                    r_ctrl_run  <= r_byte[0];
                    r_ctrl_loop <= r_byte[1];
                    r_ctrl_last <= r_byte[4 +: c_addr_w];
                    r_ctrl_wr   <= 1'b1;
                end else if (r_addr[6] && ({1'b0, w_wk} < c_depth)) begin
                    case (r_addr[1:0])
                        2'd0:    r_pat[w_wk[c_addr_w-1:0]]  <= r_byte[CHANNELS-1:0];
                        2'd1:    r_oe[w_wk[c_addr_w-1:0]]   <= r_byte[CHANNELS-1:0];
                        2'd2:    r_dur[w_wk[c_addr_w-1:0]]  <= r_byte;
                        default: r_mask[w_wk[c_addr_w-1:0]] <= r_byte[GPI_W-1:0];
                    endcase
                end
            end
        end
    end

    // ---------------- step sequencer ----------------
    logic                w_step_end;
    logic                w_load;
    logic                w_clear;
    logic                w_advance;
    logic [c_addr_w-1:0] w_load_idx;

    assign w_step_end = (r_state == ST_RUN) && (r_tick == c_tick_last) && (r_dcnt == r_cur_dur);

    // A CTRL commit takes priority over a step ending in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_advance   = 1'b0;
        w_load_idx  = '0;
        if (r_ctrl_wr && !r_ctrl_run) begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
        end else if (r_ctrl_wr && ((r_state == ST_IDLE) || (r_state == ST_DONE))) begin
            w_state_nxt = ST_RUN;
            w_load      = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_step_end) begin
                        if (r_cur_mask != '0) begin
                            w_state_nxt = ST_WAIT;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if ((r_gpi_s2 & r_cur_mask) != '0) begin
                        w_advance = 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_advance) begin
                if (r_step != r_ctrl_last) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                    w_load_idx  = r_step + 1'b1;
                end else if (r_ctrl_loop) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
        end
    end

    // Step fields are copied at load so memory writes never disturb the live step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_tick     <= '0;
            r_dcnt     <= 8'd0;
            r_cur_dur  <= 8'd0;
            r_cur_mask <= '0;
            r_mc       <= '0;
            r_oe_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_step     <= w_load_idx;
                r_mc       <= r_pat[w_load_idx];
                r_oe_out   <= r_oe[w_load_idx];
                r_cur_dur  <= r_dur[w_load_idx];
                r_cur_mask <= r_mask[w_load_idx];
                r_tick     <= '0;
                r_dcnt     <= 8'd0;
            end else if (w_clear) begin
                r_step   <= '0;
                r_mc     <= '0;
                r_oe_out <= '0;
                r_tick   <= '0;
                r_dcnt   <= 8'd0;
            end else if (r_state == ST_RUN) begin
                if (r_tick == c_tick_last) begin
                    r_tick <= '0;
                    r_dcnt <= r_dcnt + 8'd1;
                end else begin
                    r_tick <= r_tick + 1'b1;
                end
            end
        end
    end

    assign mc    = r_mc;
    assign mc_oe = r_oe_out;
    assign busy  = (r_state == ST_RUN) || (r_state == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_rtmc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtmc_seq
// Brief    : Self-checking bench for rtmc_seq (TICK_DIV = 4), SPI host model
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtmc_seq;

    localparam int HP = 6;

`ifdef RTMC_SEQ_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs_n;
    logic       sdi;
    logic       sdo;
    logic [3:0] gpi;
    logic [7:0] mc;
    logic [7:0] mc_oe;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb_q [$];
    logic [7:0] exp_pat_q [$];
    logic [7:0] exp_oe_q [$];
    int         exp_len_q [$];

    typedef struct {
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
        bit         is_step;
    } vec_t;

    vec_t vecs [8];

    rtmc_seq #(
        .CHANNELS(8),
        .DEPTH   (16),
        .GPI_W   (4),
        .TICK_DIV(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sck  (sck),
        .cs_n (cs_n),
        .sdi  (sdi),
        .sdo  (sdo),
        .gpi  (gpi),
        .mc   (mc),
        .mc_oe(mc_oe),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int busy_cnt = 0;
    int a5_cnt   = 0;
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (busy && mc == 8'hA5 && mc_oe == 8'hFF) a5_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required to end before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sdi = tx[i];
            tick(HP);
            rx[i] = sdo;
            sck = 1'b1;
            tick(HP);
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        tick(HP);
    endtask

    task automatic cs_high();
        tick(HP);
        cs_n = 1'b1;
        sdi  = 1'b0;
        tick(2 * HP);
    endtask

    task automatic spi_write(input logic [6:0] addr, input logic [7:0] d);
        logic [7:0] rx;
        cs_low();
        spi_bits({1'b1, addr}, 8, rx);
        spi_bits(d, 8, rx);
        cs_high();
    endtask

    task automatic spi_write4(input logic [6:0] addr, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] rx;
        cs_low();
        spi_bits({1'b1, addr}, 8, rx);
        spi_bits(d0, 8, rx);
        spi_bits(d1, 8, rx);
        spi_bits(d2, 8, rx);
        spi_bits(d3, 8, rx);
        cs_high();
    endtask

    task automatic spi_read_chk(input string name, input logic [6:0] addr, input logic [7:0] exp);
        logic [7:0] rx;
        logic [7:0] e;
        sb_q.push_back(exp);
        cs_low();
        spi_bits({1'b0, addr}, 8, rx);
        spi_bits(8'h00, 8, rx);
        cs_high();
        e = sb_q.pop_front();
        chk(name, {24'd0, rx}, {24'd0, e});
    endtask

    task automatic wait_busy(input string name, input logic lvl, input int bound);
        int n;
        n = 0;
        while (busy !== lvl && n < bound) begin
            tick(1);
            n++;
        end
        chk(name, {31'd0, busy}, {31'd0, lvl});
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] e;
        logic [7:0] cur;
        logic [7:0] cur_oe;
        logic [7:0] st;
        logic [7:0] pats [2];
        logic [7:0] oes [2];
        int         lens [2];
        int         b0;
        int         a0;
        int         n;
        int         phase;

        rst  = 1'b1;
        sck  = 1'b0;
        cs_n = 1'b1;
        sdi  = 1'b0;
        gpi  = 4'h0;
        tick(4);
        chk("rst_mc", {24'd0, mc}, 32'h0);
        chk("rst_oe", {24'd0, mc_oe}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_sdo", {31'd0, sdo}, 32'h0);
        rst = 1'b0;
        tick(4);
        spi_read_chk("rst_status", 7'h01, 8'h00);
        spi_read_chk("rst_ctrl", 7'h00, 8'h00);

        // register write / readback table
        vecs[0] = '{7'h00, 8'hF2, 8'hF2, 1'b0};
        vecs[1] = '{7'h00, 8'h5A, 8'h52, 1'b0};
        vecs[2] = '{7'h01, 8'hFF, 8'h00, 1'b0};
        vecs[3] = '{7'h20, 8'h77, 8'h00, 1'b0};
        vecs[4] = '{7'h45, 8'h3C, 8'h3C, 1'b1};
        vecs[5] = '{7'h47, 8'hFF, 8'h0F, 1'b1};
        vecs[6] = '{7'h7E, 8'h81, 8'h81, 1'b1};
        vecs[7] = '{7'h40, 8'h12, 8'h12, 1'b1};
        for (int i = 0; i < 8; i++) begin
            spi_write(vecs[i].addr, vecs[i].wdata);
            spi_read_chk($sformatf("vec%0d_addr%02h", i, vecs[i].addr), vecs[i].addr,
                         (vecs[i].is_step && !RB) ? 8'h00 : vecs[i].exp);
        end

        // burst read with address auto-increment
        sb_q.push_back(8'h52);
        sb_q.push_back(8'h00);
        cs_low();
        spi_bits({1'b0, 7'h00}, 8, rx);
        spi_bits(8'h00, 8, rx);
        e = sb_q.pop_front();
        chk("burst_ctrl", {24'd0, rx}, {24'd0, e});
        spi_bits(8'h00, 8, rx);
        e = sb_q.pop_front();
        chk("burst_status", {24'd0, rx}, {24'd0, e});
        cs_high();

        // single step, no loop: (2+1)*4 = 12 clk then DONE
        spi_write4(7'h40, 8'hA5, 8'hFF, 8'h02, 8'h00);
        b0 = busy_cnt;
        a0 = a5_cnt;
        spi_write(7'h00, 8'h01);
        wait_busy("single_done", 1'b0, 300);
        chk("single_busy_len", busy_cnt - b0, 12);
        chk("single_a5_len", a5_cnt - a0, 12);
        chk("single_hold_mc", {24'd0, mc}, 32'hA5);
        chk("single_hold_oe", {24'd0, mc_oe}, 32'hFF);
        spi_read_chk("single_status", 7'h01, 8'h03);

        // two-step loop
        spi_write4(7'h40, 8'h11, 8'h0F, 8'h00, 8'h00);
        spi_write4(7'h44, 8'h22, 8'hF0, 8'h01, 8'h00);
        spi_write(7'h00, 8'h13);
        wait_busy("loop_busy", 1'b1, 300);
        cur = mc;
        n   = 0;
        while (mc == cur && n < 40) begin
            tick(1);
            n++;
        end
        chk("loop_sync", {31'd0, (mc == 8'h11 || mc == 8'h22)}, 32'h1);
        pats[0] = 8'h11; oes[0] = 8'h0F; lens[0] = 4;
        pats[1] = 8'h22; oes[1] = 8'hF0; lens[1] = 8;
        phase = (mc == 8'h22) ? 1 : 0;
        for (int s = 0; s < 6; s++) begin
            exp_pat_q.push_back(pats[(phase + s) % 2]);
            exp_oe_q.push_back(oes[(phase + s) % 2]);
            exp_len_q.push_back(lens[(phase + s) % 2]);
        end
        for (int s = 0; s < 6; s++) begin
            cur    = mc;
            cur_oe = mc_oe;
            n      = 0;
            while (mc == cur && n < 40) begin
                tick(1);
                n++;
            end
            chk($sformatf("loop_seg%0d_mc", s), {24'd0, cur}, {24'd0, exp_pat_q.pop_front()});
            chk($sformatf("loop_seg%0d_oe", s), {24'd0, cur_oe}, {24'd0, exp_oe_q.pop_front()});
            chk($sformatf("loop_seg%0d_len", s), n, exp_len_q.pop_front());
        end
        cs_low();
        spi_bits({1'b0, 7'h01}, 8, rx);
        spi_bits(8'h00, 8, st);
        cs_high();
        chk("loop_status", {24'd0, st & 8'hEF}, 32'h01);
        spi_write(7'h00, 8'h00);
        chk("stop_mc", {24'd0, mc}, 32'h0);
        chk("stop_oe", {24'd0, mc_oe}, 32'h0);
        chk("stop_busy", {31'd0, busy}, 32'h0);

        // GPI wait condition
        gpi = 4'h0;
        spi_write4(7'h40, 8'h01, 8'hFF, 8'h00, 8'h04);
        spi_write4(7'h44, 8'h02, 8'hFF, 8'h00, 8'h00);
        spi_write(7'h00, 8'h11);
        tick(20);
        spi_read_chk("wait_status", 7'h01, 8'h02);
        chk("wait_mc", {24'd0, mc}, 32'h01);
        chk("wait_busy", {31'd0, busy}, 32'h1);
        gpi = 4'h4;
        n   = 0;
        while (mc != 8'h02 && n < 10) begin
            tick(1);
            n++;
        end
        chk($sformatf("wait_exit_clk%0d", n), {31'd0, (n >= 1 && n <= 3)}, 32'h1);
        wait_busy("wait_done", 1'b0, 50);
        spi_read_chk("wait_done_status", 7'h01, 8'h13);
        chk("wait_done_mc", {24'd0, mc}, 32'h02);
        gpi = 4'h0;

        // aborted write byte after 5 bits
        cs_low();
        spi_bits(8'h80, 8, rx);
        spi_bits(8'h00, 5, rx);
        cs_high();
        chk("abort_mc", {24'd0, mc}, 32'h02);
        spi_read_chk("abort_ctrl", 7'h00, 8'h11);
        spi_write(7'h00, 8'h00);
        chk("after_abort_mc", {24'd0, mc}, 32'h0);
        spi_read_chk("after_abort_ctrl", 7'h00, 8'h00);

        // reset while running
        spi_write(7'h43, 8'h00);
        spi_write(7'h00, 8'h13);
        wait_busy("pre_rst_busy", 1'b1, 300);
        tick(3);
        rst = 1'b1;
        #1;
        chk("midrst_mc", {24'd0, mc}, 32'h0);
        chk("midrst_oe", {24'd0, mc_oe}, 32'h0);
        chk("midrst_busy", {31'd0, busy}, 32'h0);
        tick(2);
        rst = 1'b0;
        tick(2);
        spi_read_chk("midrst_status", 7'h01, 8'h00);
        spi_read_chk("midrst_ctrl", 7'h00, 8'h00);
        spi_read_chk("midrst_step0", 7'h40, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
